id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath width.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-low):
  clk  in  1  rising-edge clock
  rst_n  in  1  synchronous active-low reset
  id_valid  in  1  decode slot holds an instruction
  id_pc  in  XLEN  decode PC
  id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices
  id_rs1_data, id_rs2_data  in  XLEN  register-file read data
  id_imm  in  XLEN  sign-extended immediate
  id_alu_sel  in  4  ALU operation code
  id_src1_pc  in  1  operand 1 = PC instead of rs1
  id_src2_imm  in  1  operand 2 = immediate instead of rs2
  id_reg_we, id_mem_rd, id_mem_wr  in  1  writeback / load / store flags
  ex_alu_result  in  XLEN  ALU result of instruction currently in EX
  mem_rd_addr  in  5, mem_reg_we in 1, mem_data in XLEN  MEM-stage writeback info
  wb_rd_addr  in  5, wb_reg_we in 1, wb_data in XLEN  WB-stage writeback info
  hold_in  in  1  downstream freeze request
  flush  in  1  squash decode slot (taken branch/jump)
  ex_valid  out  1  EX slot valid
  ex_pc  out  XLEN  latched PC
  ex_i_1, ex_i_2  out  XLEN  ALU operands
  ex_alu_sel  out  4  ALU operation code
  ex_store_data  out  XLEN  forwarded rs2 for stores
  ex_rd_addr  out  5; ex_reg_we, ex_mem_rd, ex_mem_wr  out  1  control
  stall_id  out  1  hold IF/ID this cycle

Function
REQ-003 SHALL register all ex_* outputs on rising clk; decode-to-EX latency exactly 1 cycle.
REQ-004 SHALL select rs1 source, highest priority first: x0 -> 0; EX match (ex_valid, ex_reg_we, !ex_mem_rd, ex_rd_addr==rs1) -> ex_alu_result; MEM match (mem_reg_we, mem_rd_addr==rs1) -> mem_data; WB match -> wb_data; else id_rs1_data.
REQ-005 SHALL apply identical selection to rs2.
REQ-006 SHALL never forward to or from index 0; reads of x0 yield 0 regardless of id_rs*_data.
REQ-007 SHALL latch ex_i_1 = id_src1_pc ? id_pc : fwd_rs1; ex_i_2 = id_src2_imm ? id_imm : fwd_rs2; ex_store_data = fwd_rs2 always.
REQ-008 SHALL detect load-use: ex_valid & ex_mem_rd & ex_rd_addr!=0 & id_valid & (ex_rd_addr==id_rs1_addr | (ex_rd_addr==id_rs2_addr & (!id_src2_imm | id_mem_wr))).
REQ-009 On load-use (no flush, no hold): stall_id=1 combinationally; next cycle ex_valid=0 with ex_reg_we=ex_mem_rd=ex_mem_wr=0 (bubble); decode instruction re-presented and accepted next cycle via MEM forwarding.
REQ-010 hold_in=1 (no flush): all EX registers keep value; stall_id=1.
REQ-011 flush=1: next cycle ex_valid=0 and all control flags 0; stall_id=0; overrides hold_in and load-use.
REQ-012 Priority: rst_n low > flush > hold_in > load-use > normal load.
REQ-013 id_valid=0 (no stall) SHALL load a bubble: ex_valid=0, control flags 0.
REQ-014 Control flags SHALL be 0 whenever ex_valid=0; datapath registers in bubbles are don't-care but SHALL not be X after reset.
REQ-015 stall_id SHALL be purely combinational from current inputs and EX registers; no multi-cycle stall state beyond the EX registers.

Reset
REQ-016 rst_n=0 at a clk edge SHALL clear every ex_* output to 0 (ex_alu_sel=4'b0000) and ex_valid=0.
REQ-017 stall_id SHALL be 0 while in reset state (ex_valid=0 prevents load-use).
REQ-018 Reset mid-stall or mid-hold SHALL discard the held instruction; first post-reset edge with id_valid=1 loads normally.

Verification
REQ-019 ADD x3,x1,x2 with rs1=5, rs2=7, no matches -> next cycle ex_valid=1, ex_i_1=5, ex_i_2=7, ex_rd_addr=3.
REQ-020 EX holds x3 writer (ex_alu_result=12), MEM writes x3=99, decode reads x3 -> ex_i_1=12 (EX beats MEM).
REQ-021 EX holds LW x4, decode ADD uses x4 -> stall_id=1 one cycle, bubble ex_valid=0; following cycle with mem_rd_addr=4, mem_data=0xABCD -> ex_i_1=0xABCD.
REQ-022 Decode reads x0 while WB writes x0=0xFFFF -> ex_i_1=0.
REQ-023 hold_in=1 for 3 cycles with changing decode inputs -> ex_* unchanged, stall_id=1; flush asserted together with hold_in -> next ex_valid=0.
REQ-024 rst_n=0 during load-use stall -> all ex_* 0, stall_id=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection; 1-cycle decode-to-EX latency.
// Backpressure: hold_in freezes EX and stalls decode; a load-use hazard inserts one bubble; flush squashes the decode slot.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_src1_pc,
    input  logic            id_src2_imm,
    input  logic            id_reg_we,
    input  logic            id_mem_rd,
    input  logic            id_mem_wr,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_we,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic            hold_in,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_i_1,
    output logic [XLEN-1:0] ex_i_2,
    output logic [3:0]      ex_alu_sel,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic            stall_id
);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic [XLEN-1:0] ex_i_1_q, ex_i_1_d;
    logic [XLEN-1:0] ex_i_2_q, ex_i_2_d;
    logic [3:0]      ex_alu_sel_q, ex_alu_sel_d;
    logic [XLEN-1:0] ex_store_data_q, ex_store_data_d;
    logic [4:0]      ex_rd_addr_q, ex_rd_addr_d;
    logic            ex_reg_we_q, ex_reg_we_d;
    logic            ex_mem_rd_q, ex_mem_rd_d;
    logic            ex_mem_wr_q, ex_mem_wr_d;

    logic            ex_fwd_ok;
    logic            load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_dat,
        input logic            ex_ok,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_res,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_dat,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_dat
    );
        logic [XLEN-1:0] r;
        if (addr == 5'd0)                    r = '0;
        else if (ex_ok && (ex_rd == addr))   r = ex_res;
        else if (m_we && (m_rd == addr))     r = m_dat;
        else if (w_we && (w_rd == addr))     r = w_dat;
        else                                 r = rf_dat;
        return r;
    endfunction

    // A load in EX has no result yet, so it never forwards; the hazard logic covers it.
    assign ex_fwd_ok = ex_valid_q & ex_reg_we_q & ~ex_mem_rd_q;

    assign fwd_rs1 = fwd_sel(id_rs1_addr, id_rs1_data, ex_fwd_ok, ex_rd_addr_q, ex_alu_result,
                             mem_reg_we, mem_rd_addr, mem_data, wb_reg_we, wb_rd_addr, wb_data);
    assign fwd_rs2 = fwd_sel(id_rs2_addr, id_rs2_data, ex_fwd_ok, ex_rd_addr_q, ex_alu_result,
                             mem_reg_we, mem_rd_addr, mem_data, wb_reg_we, wb_rd_addr, wb_data);

    assign load_use = ex_valid_q & ex_mem_rd_q & (ex_rd_addr_q != 5'd0) & id_valid &
                      ((ex_rd_addr_q == id_rs1_addr) |
                       ((ex_rd_addr_q == id_rs2_addr) & (~id_src2_imm | id_mem_wr)));

    assign stall_id = rst_n & ~flush & (hold_in | load_use);

    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_i_1_d        = ex_i_1_q;
        ex_i_2_d        = ex_i_2_q;
        ex_alu_sel_d    = ex_alu_sel_q;
        ex_store_data_d = ex_store_data_q;
        ex_rd_addr_d    = ex_rd_addr_q;
        ex_reg_we_d     = ex_reg_we_q;
        ex_mem_rd_d     = ex_mem_rd_q;
        ex_mem_wr_d     = ex_mem_wr_q;
        if (flush || !hold_in) begin
            // Datapath always follows decode; only valid and control distinguish a bubble.
            ex_pc_d         = id_pc;
            ex_i_1_d        = id_src1_pc ? id_pc : fwd_rs1;
            ex_i_2_d        = id_src2_imm ? id_imm : fwd_rs2;
            ex_alu_sel_d    = id_alu_sel;
            ex_store_data_d = fwd_rs2;
            ex_rd_addr_d    = id_rd_addr;
            if (flush || load_use || !id_valid) begin
                ex_valid_d  = 1'b0;
                ex_reg_we_d = 1'b0;
                ex_mem_rd_d = 1'b0;
                ex_mem_wr_d = 1'b0;
            end else begin
                ex_valid_d  = 1'b1;
                ex_reg_we_d = id_reg_we;
                ex_mem_rd_d = id_mem_rd;
                ex_mem_wr_d = id_mem_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_i_1_q        <= '0;
            ex_i_2_q        <= '0;
            ex_alu_sel_q    <= 4'b0000;
            ex_store_data_q <= '0;
            ex_rd_addr_q    <= 5'd0;
            ex_reg_we_q     <= 1'b0;
            ex_mem_rd_q     <= 1'b0;
            ex_mem_wr_q     <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_i_1_q        <= ex_i_1_d;
            ex_i_2_q        <= ex_i_2_d;
            ex_alu_sel_q    <= ex_alu_sel_d;
            ex_store_data_q <= ex_store_data_d;
            ex_rd_addr_q    <= ex_rd_addr_d;
            ex_reg_we_q     <= ex_reg_we_d;
            ex_mem_rd_q     <= ex_mem_rd_d;
            ex_mem_wr_q     <= ex_mem_wr_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_i_1        = ex_i_1_q;
    assign ex_i_2        = ex_i_2_q;
    assign ex_alu_sel    = ex_alu_sel_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_rd_addr    = ex_rd_addr_q;
    assign ex_reg_we     = ex_reg_we_q;
    assign ex_mem_rd     = ex_mem_rd_q;
    assign ex_mem_wr     = ex_mem_wr_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, hand-written hazard/hold/reset sequences, and a random run against a reference model.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_sel;
    logic        id_src1_pc, id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr;
    logic [31:0] ex_alu_result;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_we;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_we;
    logic [31:0] wb_data;
    logic        hold_in, flush;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_i_1, ex_i_2, ex_store_data;
    logic [3:0]  ex_alu_sel;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr, stall_id;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_sel(id_alu_sel), .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
        .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .ex_alu_result(ex_alu_result), .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we),
        .mem_data(mem_data), .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we), .wb_data(wb_data),
        .hold_in(hold_in), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_i_1(ex_i_1), .ex_i_2(ex_i_2), .ex_alu_sel(ex_alu_sel), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .stall_id(stall_id)
    );

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, imm;
        logic [3:0]  alu;
        logic        src1_pc, src2_imm, we, mrd, mwr;
        logic [31:0] ex_res;
        logic [4:0]  m_rd;
        logic        m_we;
        logic [31:0] m_dat;
        logic [4:0]  w_rd;
        logic        w_we;
        logic [31:0] w_dat;
        logic        hold, flush;
    } in_t;

    typedef struct packed {
        logic        known;
        logic        valid;
        logic [31:0] pc, i1, i2, store;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we, mrd, mwr;
    } ex_t;

    typedef struct {
        in_t         in;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_i1, exp_i2;
        logic [4:0]  exp_rd;
    } vec_t;

    int checks = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic in_t idle();
        in_t x = '0;
        x.rst_n = 1'b1;
        x.pc    = 32'h100;
        return x;
    endfunction

    function automatic in_t alu_op(input logic [4:0] rd, input logic [4:0] r1, input logic [31:0] d1,
                                   input logic [4:0] r2, input logic [31:0] d2);
        in_t x = idle();
        x.valid = 1'b1;
        x.we    = 1'b1;
        x.rda   = rd;
        x.rs1a  = r1;
        x.rs1d  = d1;
        x.rs2a  = r2;
        x.rs2d  = d2;
        return x;
    endfunction

    function automatic in_t load_op(input logic [4:0] rd, input logic [4:0] r1, input logic [31:0] d1);
        in_t x = alu_op(rd, r1, d1, 5'd0, 32'h0);
        x.mrd      = 1'b1;
        x.src2_imm = 1'b1;
        x.imm      = 32'd4;
        return x;
    endfunction

    task automatic drive(input in_t x);
        rst_n = x.rst_n;           id_valid = x.valid;       id_pc = x.pc;
        id_rs1_addr = x.rs1a;      id_rs2_addr = x.rs2a;     id_rd_addr = x.rda;
        id_rs1_data = x.rs1d;      id_rs2_data = x.rs2d;     id_imm = x.imm;
        id_alu_sel = x.alu;        id_src1_pc = x.src1_pc;   id_src2_imm = x.src2_imm;
        id_reg_we = x.we;          id_mem_rd = x.mrd;        id_mem_wr = x.mwr;
        ex_alu_result = x.ex_res;  mem_rd_addr = x.m_rd;     mem_reg_we = x.m_we;
        mem_data = x.m_dat;        wb_rd_addr = x.w_rd;      wb_reg_we = x.w_we;
        wb_data = x.w_dat;         hold_in = x.hold;         flush = x.flush;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the operand an instruction should see is the youngest in-flight
    // producer of that register, with x0 hard-wired and an in-flight load not yet usable.
    function automatic logic [31:0] ref_operand(input ex_t m, input in_t x, input logic [4:0] a,
                                                input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (m.valid && m.we && !m.mrd && m.rd == a) return x.ex_res;
        if (x.m_we && x.m_rd == a) return x.m_dat;
        if (x.w_we && x.w_rd == a) return x.w_dat;
        return rf;
    endfunction

    function automatic logic ref_hazard(input ex_t m, input in_t x);
        logic reads_rs2;
        reads_rs2 = !x.src2_imm || x.mwr;
        return m.valid && m.mrd && m.rd != 0 && x.valid &&
               (m.rd == x.rs1a || (reads_rs2 && m.rd == x.rs2a));
    endfunction

    function automatic logic ref_stall(input ex_t m, input in_t x);
        return x.rst_n && !x.flush && (x.hold || ref_hazard(m, x));
    endfunction

    function automatic ex_t ref_next(input ex_t m, input in_t x);
        ex_t n;
        logic [31:0] o1, o2;
        n = m;
        if (!x.rst_n) begin
            n = '0;
            n.known = 1'b1;
        end else if (x.hold && !x.flush) begin
            n = m;
        end else if (x.flush || !x.valid || ref_hazard(m, x)) begin
            n = '0;
        end else begin
            o1 = ref_operand(m, x, x.rs1a, x.rs1d);
            o2 = ref_operand(m, x, x.rs2a, x.rs2d);
            n.known = 1'b1;
            n.valid = 1'b1;
            n.pc    = x.pc;
            n.i1    = x.src1_pc ? x.pc : o1;
            n.i2    = x.src2_imm ? x.imm : o2;
            n.store = o2;
            n.alu   = x.alu;
            n.rd    = x.rda;
            n.we    = x.we;
            n.mrd   = x.mrd;
            n.mwr   = x.mwr;
        end
        return n;
    endfunction

    task automatic cmp_model(input ex_t m, input int cyc);
        chk($sformatf("rnd%0d ex_valid", cyc), 32'(ex_valid), 32'(m.valid));
        chk($sformatf("rnd%0d ex_flags", cyc), {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr},
            {29'd0, m.we, m.mrd, m.mwr});
        if (m.known) begin
            chk($sformatf("rnd%0d ex_pc", cyc), ex_pc, m.pc);
            chk($sformatf("rnd%0d ex_i_1", cyc), ex_i_1, m.i1);
            chk($sformatf("rnd%0d ex_i_2", cyc), ex_i_2, m.i2);
            chk($sformatf("rnd%0d ex_store", cyc), ex_store_data, m.store);
            chk($sformatf("rnd%0d ex_alu_sel", cyc), 32'(ex_alu_sel), 32'(m.alu));
            chk($sformatf("rnd%0d ex_rd", cyc), 32'(ex_rd_addr), 32'(m.rd));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid"}, 32'(ex_valid), 32'h0);
        chk({tag, " pc"}, ex_pc, 32'h0);
        chk({tag, " i_1"}, ex_i_1, 32'h0);
        chk({tag, " i_2"}, ex_i_2, 32'h0);
        chk({tag, " store"}, ex_store_data, 32'h0);
        chk({tag, " alu_sel"}, 32'(ex_alu_sel), 32'h0);
        chk({tag, " rd"}, 32'(ex_rd_addr), 32'h0);
        chk({tag, " flags"}, {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[6];
        in_t  x;
        ex_t  m;

        // Table entries run back to back; each expectation accounts for the entry before it.
        v[0].in = alu_op(5'd3, 5'd1, 32'd5, 5'd2, 32'd7);
        v[0].exp_stall = 0; v[0].exp_valid = 1; v[0].exp_i1 = 32'd5; v[0].exp_i2 = 32'd7; v[0].exp_rd = 5'd3;

        v[1].in = alu_op(5'd5, 5'd3, 32'd1, 5'd0, 32'h55);
        v[1].in.ex_res = 32'd12; v[1].in.m_we = 1; v[1].in.m_rd = 5'd3; v[1].in.m_dat = 32'd99;
        v[1].exp_stall = 0; v[1].exp_valid = 1; v[1].exp_i1 = 32'd12; v[1].exp_i2 = 32'h0; v[1].exp_rd = 5'd5;

        v[2].in = alu_op(5'd7, 5'd0, 32'h1234, 5'd6, 32'd8);
        v[2].in.w_we = 1; v[2].in.w_rd = 5'd0; v[2].in.w_dat = 32'hFFFF;
        v[2].in.m_we = 1; v[2].in.m_rd = 5'd6; v[2].in.m_dat = 32'h77;
        v[2].exp_stall = 0; v[2].exp_valid = 1; v[2].exp_i1 = 32'h0; v[2].exp_i2 = 32'h77; v[2].exp_rd = 5'd7;

        v[3].in = alu_op(5'd8, 5'd9, 32'd1, 5'd10, 32'd2);
        v[3].in.src2_imm = 1; v[3].in.imm = 32'h100;
        v[3].in.w_we = 1; v[3].in.w_rd = 5'd9; v[3].in.w_dat = 32'h42;
        v[3].exp_stall = 0; v[3].exp_valid = 1; v[3].exp_i1 = 32'h42; v[3].exp_i2 = 32'h100; v[3].exp_rd = 5'd8;

        v[4].in = load_op(5'd4, 5'd1, 32'h1000);
        v[4].exp_stall = 0; v[4].exp_valid = 1; v[4].exp_i1 = 32'h1000; v[4].exp_i2 = 32'd4; v[4].exp_rd = 5'd4;

        v[5].in = alu_op(5'd6, 5'd4, 32'd1, 5'd4, 32'd2);
        v[5].in.valid = 0;
        v[5].exp_stall = 0; v[5].exp_valid = 0; v[5].exp_i1 = 0; v[5].exp_i2 = 0; v[5].exp_rd = 0;

        // Reset state
        x = idle(); x.rst_n = 0; x.valid = 1; x.hold = 1;
        drive(x);
        step();
        step();
        chk_all_zero("reset");
        x = idle(); drive(x); #1;
        chk("reset stall_id", 32'(stall_id), 32'h0);

        for (int i = 0; i < 6; i++) begin
            drive(v[i].in);
            #1;
            chk($sformatf("vec%0d stall_id", i), 32'(stall_id), 32'(v[i].exp_stall));
            step();
            chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(v[i].exp_valid));
            if (v[i].exp_valid) begin
                chk($sformatf("vec%0d ex_i_1", i), ex_i_1, v[i].exp_i1);
                chk($sformatf("vec%0d ex_i_2", i), ex_i_2, v[i].exp_i2);
                chk($sformatf("vec%0d ex_rd", i), 32'(ex_rd_addr), 32'(v[i].exp_rd));
            end else begin
                chk($sformatf("vec%0d bubble flags", i), {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr}, 32'h0);
            end
        end

        // Load-use: one bubble, then the dependent op picks the loaded value up from MEM
        drive(load_op(5'd4, 5'd2, 32'h2000));
        step();
        x = alu_op(5'd6, 5'd4, 32'hDEAD, 5'd1, 32'd3);
        drive(x); #1;
        chk("lu stall_id", 32'(stall_id), 32'h1);
        step();
        chk("lu bubble valid", 32'(ex_valid), 32'h0);
        chk("lu bubble flags", {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr}, 32'h0);
        x.m_we = 1; x.m_rd = 5'd4; x.m_dat = 32'hABCD;
        drive(x); #1;
        chk("lu retry stall_id", 32'(stall_id), 32'h0);
        step();
        chk("lu retry valid", 32'(ex_valid), 32'h1);
        chk("lu retry i_1", ex_i_1, 32'hABCD);
        chk("lu retry i_2", ex_i_2, 32'd3);

        // Hold for three cycles with shifting decode inputs, then flush wins over hold
        for (int k = 0; k < 3; k++) begin
            x = alu_op(5'(10 + k), 5'(1 + k), 32'(k * 17), 5'd2, 32'h9);
            x.hold = 1;
            drive(x); #1;
            chk($sformatf("hold%0d stall_id", k), 32'(stall_id), 32'h1);
            step();
            chk($sformatf("hold%0d valid", k), 32'(ex_valid), 32'h1);
            chk($sformatf("hold%0d i_1", k), ex_i_1, 32'hABCD);
            chk($sformatf("hold%0d i_2", k), ex_i_2, 32'd3);
            chk($sformatf("hold%0d rd", k), 32'(ex_rd_addr), 32'd6);
            chk($sformatf("hold%0d reg_we", k), 32'(ex_reg_we), 32'h1);
        end
        x.flush = 1;
        drive(x); #1;
        chk("flush+hold stall_id", 32'(stall_id), 32'h0);
        step();
        chk("flush valid", 32'(ex_valid), 32'h0);
        chk("flush flags", {29'd0, ex_reg_we, ex_mem_rd, ex_mem_wr}, 32'h0);

        // Reset during a load-use stall discards everything; next decode loads normally
        drive(load_op(5'd4, 5'd2, 32'h2000));
        step();
        x = alu_op(5'd6, 5'd4, 32'h1, 5'd1, 32'd3);
        drive(x); #1;
        chk("rst-lu stall_id", 32'(stall_id), 32'h1);
        x.rst_n = 0;
        drive(x);
        step();
        chk_all_zero("rst-lu");
        drive(alu_op(5'd3, 5'd1, 32'd5, 5'd2, 32'd7)); #1;
        chk("post-rst stall_id", 32'(stall_id), 32'h0);
        step();
        chk("post-rst valid", 32'(ex_valid), 32'h1);
        chk("post-rst i_1", ex_i_1, 32'd5);

        // Random run against the reference model
        x = idle(); x.rst_n = 0;
        drive(x);
        step();
        m = '0;
        m.known = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            x = idle();
            x.rst_n    = ($urandom_range(0, 99) != 0);
            x.valid    = ($urandom_range(0, 99) < 85);
            x.pc       = $urandom;
            x.rs1a     = 5'($urandom_range(0, 7));
            x.rs2a     = 5'($urandom_range(0, 7));
            x.rda      = 5'($urandom_range(0, 7));
            x.rs1d     = $urandom;
            x.rs2d     = $urandom;
            x.imm      = $urandom;
            x.alu      = 4'($urandom_range(0, 15));
            x.src1_pc  = ($urandom_range(0, 4) == 0);
            x.src2_imm = $urandom_range(0, 1) == 1;
            x.we       = $urandom_range(0, 1) == 1;
            x.mrd      = ($urandom_range(0, 2) == 0);
            x.mwr      = !x.mrd && ($urandom_range(0, 3) == 0);
            x.ex_res   = $urandom;
            x.m_rd     = 5'($urandom_range(0, 7));
            x.m_we     = $urandom_range(0, 1) == 1;
            x.m_dat    = $urandom;
            x.w_rd     = 5'($urandom_range(0, 7));
            x.w_we     = $urandom_range(0, 1) == 1;
            x.w_dat    = $urandom;
            x.hold     = ($urandom_range(0, 9) == 0);
            x.flush    = ($urandom_range(0, 19) == 0);
            drive(x); #1;
            chk($sformatf("rnd%0d stall_id", c), 32'(stall_id), 32'(ref_stall(m, x)));
            step();
            m = ref_next(m, x);
            cmp_model(m, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
